comparator_stim_gen: RTL and testbench

Operand-pair generator for the 1-bit/N-bit comparator datapath. It works from a requested relation (equal, greater, less) back to operands: it emits a programmed number of pseudo-random (a, b) pairs, each guaranteed to satisfy that relation. Output uses a valid/ready handshake. It sits in front of the comparator as its self-test and FPGA-demo stimulus source, and the comparator's Eq/gt/lt outputs can be checked against the requested relation.

---
 rtl/comparator_stim_gen.sv | 126 ++++++++++++
 tb/tb_comparator_stim_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_stim_gen.sv
// Operand-pair generator: emits `count` pseudo-random (a, b) pairs that
// satisfy a requested relation (eq / gt / lt) over a valid/ready handshake.
module comparator_stim_gen #(
   parameter int          WIDTH = 4,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       rel,
   input  logic [7:0]       count,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam logic [1:0] REL_EQ = 2'b00;
   localparam logic [1:0] REL_LT = 2'b10;

   state_t          state_q;
   state_t          state_d;
   logic [15:0]     lfsr_q;
   logic [1:0]      rel_q;
   logic [7:0]      remaining_q;
   logic            err_q;

   logic            hs;
   logic            bad_req;
   logic            accept;
   logic            fb;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] gt_a;
   logic [WIDTH-1:0] gt_b;

   assign hs      = (state_q == PRESENT) && out_ready;
   assign bad_req = (rel == 2'b11) || (count == 8'd0);
   assign accept  = (state_q == IDLE) && start && !bad_req;
   assign fb      = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = PRESENT;
         PRESENT: if (hs && remaining_q == 8'd1) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         lfsr_q      <= SEED;
         rel_q       <= REL_EQ;
         remaining_q <= 8'd0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= (state_q == IDLE) && start && bad_req;
         if (accept) begin
            rel_q       <= rel;
            remaining_q <= count;
         end
         if (hs) begin
            lfsr_q      <= {lfsr_q[14:0], fb};
            remaining_q <= remaining_q - 8'd1;
         end
      end
   end

   assign x = lfsr_q[WIDTH-1:0];
   assign y = lfsr_q[2*WIDTH-1:WIDTH];

   // Equal halves are nudged apart so a strict ordering always exists.
   always_comb begin
      gt_a = x;
      gt_b = y;
      if (x > y) begin
         gt_a = x;
         gt_b = y;
      end else if (x < y) begin
         gt_a = y;
         gt_b = x;
      end else if (x != '0) begin
         gt_a = x;
         gt_b = x - WIDTH'(1);
      end else begin
         gt_a = WIDTH'(1);
         gt_b = '0;
      end
   end

   always_comb begin
      a = '0;
      b = '0;
      if (state_q == PRESENT) begin
         if (rel_q == REL_EQ) begin
            a = x;
            b = x;
         end else if (rel_q == REL_LT) begin
            a = gt_b;
            b = gt_a;
         end else begin
            a = gt_a;
            b = gt_b;
         end
      end
   end

   assign out_valid = (state_q == PRESENT);
   assign busy      = out_valid;
   assign done      = (state_q == DONE);
   assign err       = err_q;

endmodule

// File: tb/tb_comparator_stim_gen.sv
// Bench for comparator_stim_gen: directed scenarios plus randomized
// relation runs at WIDTH=4 and WIDTH=1 against a behavioural model.
module tb_comparator_stim_gen;

   localparam logic [15:0] SEED = 16'hACE1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] rel = 2'b00;
   logic [7:0] count = 8'd0;
   logic       out_ready = 1'b0;

   logic [3:0] a4, b4;
   logic       v4, busy4, done4, err4;
   logic [0:0] a1, b1;
   logic       v1, busy1, done1, err1;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] m_lfsr = SEED;
   logic [1:0]  m_rel = 2'b00;

   always #5 clk = ~clk;

   comparator_stim_gen #(.WIDTH(4), .SEED(SEED)) u4 (
      .clk(clk), .rst(rst), .start(start), .rel(rel), .count(count),
      .out_valid(v4), .out_ready(out_ready), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .err(err4)
   );

   comparator_stim_gen #(.WIDTH(1), .SEED(SEED)) u1 (
      .clk(clk), .rst(rst), .start(start), .rel(rel), .count(count),
      .out_valid(v1), .out_ready(out_ready), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .err(err1)
   );

   function automatic logic [15:0] lfsr_next(input logic [15:0] r);
      return {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
   endfunction

   // Reference pair: take the two halves, order them, and break ties
   // by stepping the larger one down (or 1/0 when both are zero).
   function automatic void model(input logic [15:0] r, input logic [1:0] rl,
                                 input int w, output int ea, output int eb);
      int x, y, hi, lo;
      x  = int'(r) % (1 << w);
      y  = (int'(r) >> w) % (1 << w);
      hi = (x > y) ? x : y;
      lo = (x > y) ? y : x;
      if (hi == lo) begin
         if (hi != 0) lo = hi - 1;
         else hi = 1;
      end
      case (rl)
         2'b00:   begin ea = x;  eb = x;  end
         2'b01:   begin ea = hi; eb = lo; end
         default: begin ea = lo; eb = hi; end
      endcase
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      if (rst) m_lfsr = SEED;
      else if (v4 && out_ready) m_lfsr = lfsr_next(m_lfsr);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_out"}, {v4, busy4, done4, err4, a4, b4},
          0);
      chk({tag, "_out1"}, {v1, busy1, done1, err1, a1, b1}, 0);
   endtask

   task automatic chk_model(input string tag);
      int ea, eb;
      model(m_lfsr, m_rel, 4, ea, eb);
      chk({tag, "_pair4"}, {a4, b4}, (ea << 4) | eb);
      model(m_lfsr, m_rel, 1, ea, eb);
      chk({tag, "_pair1"}, {a1, b1}, (ea << 1) | eb);
   endtask

   function automatic bit rel_ok(input int x, input int y, input logic [1:0] rl);
      case (rl)
         2'b00:   return x == y;
         2'b01:   return x > y;
         default: return x < y;
      endcase
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      out_ready = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic run_random(input logic [1:0] r);
      int hs;
      bit seen_done;
      hs = 0;
      seen_done = 0;
      rel = r;
      count = 8'd255;
      start = 1'b1;
      m_rel = r;
      out_ready = 1'($urandom);
      cyc();
      for (int i = 0; i < 3000 && !seen_done; i++) begin
         if (v4) begin
            chk_model("rnd");
            chk("rnd_rel4", int'(rel_ok(int'(a4), int'(b4), m_rel)), 1);
            chk("rnd_rel1", int'(rel_ok(int'(a1), int'(b1), m_rel)), 1);
            chk("rnd_busy", {busy4, busy1, v1}, 3'b111);
         end
         chk("rnd_err", {err4, err1}, 0);
         rel = 2'($urandom);
         count = 8'($urandom);
         start = 1'($urandom);
         out_ready = 1'($urandom);
         if (v4 && out_ready) hs++;
         cyc();
         if (done4) seen_done = 1;
      end
      start = 1'b0;
      chk("rnd_hs", hs, 255);
      chk("rnd_done", {done4, done1, v4}, 3'b110);
      cyc();
      chk("rnd_after", {done4, v4, err4}, 0);
   endtask

   initial begin
      // Reset values
      do_reset();
      chk_idle("reset");

      // Equal run, count 2
      start = 1'b1; rel = 2'b00; count = 8'd2; out_ready = 1'b1; m_rel = 2'b00;
      cyc();
      start = 1'b0;
      chk("eq_p0", {v4, busy4, a4, b4}, {2'b11, 8'h11});
      chk_model("eq_p0");
      cyc();
      chk("eq_p1", {v4, a4, b4}, {1'b1, 8'h33});
      chk_model("eq_p1");
      cyc();
      chk("eq_done", {done4, v4, a4, b4}, {1'b1, 9'h0});
      cyc();
      chk("eq_idle", {done4, v4, busy4}, 0);

      // Greater run, start pulsed during DONE must be ignored
      do_reset();
      start = 1'b1; rel = 2'b01; count = 8'd2; out_ready = 1'b1; m_rel = 2'b01;
      cyc();
      start = 1'b0; rel = 2'b10; count = 8'd9;
      chk("gt_p0", {a4, b4}, 8'hE1);
      chk("gt_cmp0", int'(a4 > b4), 1);
      cyc();
      chk("gt_p1", {a4, b4}, 8'hC3);
      chk_model("gt_p1");
      cyc();
      chk("gt_done", done4, 1);
      start = 1'b1; rel = 2'b00; count = 8'd1;
      cyc();
      start = 1'b0;
      chk("gt_start_in_done", {v4, done4, err4}, 0);
      cyc();
      chk("gt_still_idle", v4, 0);

      // Less run with 3 stalled cycles
      do_reset();
      start = 1'b1; rel = 2'b10; count = 8'd1; out_ready = 1'b0; m_rel = 2'b10;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("lt_stall", {v4, done4, a4, b4}, {2'b10, 8'h1E});
         cyc();
      end
      chk("lt_stall_end", {v4, a4, b4}, {1'b1, 8'h1E});
      out_ready = 1'b1;
      cyc();
      chk("lt_done", {done4, v4}, 2'b10);
      out_ready = 1'b0;
      cyc();
      chk("lt_idle", done4, 0);

      // Illegal requests
      start = 1'b1; rel = 2'b11; count = 8'd3;
      cyc();
      start = 1'b0;
      chk("ill_rel", {err4, busy4, v4}, 3'b100);
      cyc();
      chk("ill_rel_pulse", {err4, busy4, v4}, 0);
      start = 1'b1; rel = 2'b01; count = 8'd0;
      cyc();
      start = 1'b0;
      chk("ill_cnt", {err4, busy4, v4, err1}, 4'b1001);
      cyc();
      chk("ill_cnt_pulse", {err4, busy4, v4}, 0);

      // Reset mid-run, then LFSR must restart at SEED
      start = 1'b1; rel = 2'b00; count = 8'd5; out_ready = 1'b1; m_rel = 2'b00;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      chk("mid_running", v4, 1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk_idle("mid_rst");
      out_ready = 1'b0;
      start = 1'b1; rel = 2'b00; count = 8'd1;
      cyc();
      start = 1'b0;
      chk("mid_restart", {v4, a4, b4}, {1'b1, 8'h11});
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      cyc();

      // Randomized runs for each legal relation, both widths
      for (int r = 0; r < 3; r++) run_random(2'(r));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
